// File: rtl/fnd_scan_driver.sv
// Stopwatch display back-end: sequential double-dabble binary->BCD plus a 4-digit FND scanner.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits; the ones digit is always shown.
module fnd_scan_driver #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ   = 1_000,
    parameter int MAX_VALUE = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] bin,
    output logic [15:0] bcd,
    output logic        bcd_done,
    output logic [7:0]  seg,
    output logic [3:0]  seg_comm
);

    localparam int              DIV      = CLK_HZ / SCAN_HZ;
    localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRESC_TC = PW'(DIV - 1);
    localparam logic [13:0]     MAX_BIN  = 14'(MAX_VALUE);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] bcd_sr_q, bcd_sr_d;
    logic [13:0] bin_sr_q, bin_sr_d;
    logic [3:0]  iter_q, iter_d;
    logic [15:0] bcd_q, bcd_d;
    logic        done_q, done_d;
    logic [14:0] bcd_adj;

    // Add-3 correction per nibble; the top nibble only needs its low 3 bits after the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_sr_q[4*gi +: 4] >= 4'd5) ?
                                        bcd_sr_q[4*gi +: 4] + 4'd3 : bcd_sr_q[4*gi +: 4];
        end
    endgenerate
    assign bcd_adj[14:12] = (bcd_sr_q[15:12] >= 4'd5) ? bcd_sr_q[14:12] + 3'd3 : bcd_sr_q[14:12];

    always_comb begin
        state_d  = state_q;
        bcd_sr_d = bcd_sr_q;
        bin_sr_d = bin_sr_q;
        iter_d   = iter_q;
        bcd_d    = bcd_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bin_sr_d = (bin > MAX_BIN) ? MAX_BIN : bin;
                bcd_sr_d = 16'h0000;
                iter_d   = 4'd14;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                bcd_sr_d = {bcd_adj, bin_sr_q[13]};
                bin_sr_d = {bin_sr_q[12:0], 1'b0};
                iter_d   = iter_q - 4'd1;
                // Publish on the last shift so bcd and bcd_done are both visible during DONE.
                if (iter_q == 4'd1) begin
                    bcd_d   = {bcd_adj, bin_sr_q[13]};
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            bcd_sr_q <= 16'h0000;
            bin_sr_q <= 14'h0000;
            iter_q   <= 4'd0;
            bcd_q    <= 16'h0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_sr_q <= bcd_sr_d;
            bin_sr_q <= bin_sr_d;
            iter_q   <= iter_d;
            bcd_q    <= bcd_d;
            done_q   <= done_d;
        end
    end

    assign bcd      = bcd_q;
    assign bcd_done = done_q;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_TC) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
    end

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 8'hC0;
            4'd1:    seg_decode = 8'hF9;
            4'd2:    seg_decode = 8'hA4;
            4'd3:    seg_decode = 8'hB0;
            4'd4:    seg_decode = 8'h99;
            4'd5:    seg_decode = 8'h92;
            4'd6:    seg_decode = 8'h82;
            4'd7:    seg_decode = 8'hF8;
            4'd8:    seg_decode = 8'h80;
            4'd9:    seg_decode = 8'h90;
            default: seg_decode = 8'hFF;
        endcase
    endfunction

    logic [7:0] seg_dig [4];
    logic [3:0] blank;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            assign seg_dig[gi] = seg_decode(bcd_q[4*gi +: 4]);
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    assign blank[3] = (bcd_q[15:12] == 4'd0);
    assign blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
    assign blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
    assign blank[0] = 1'b0;
`else
    assign blank = 4'b0000;
`endif

    logic [7:0] seg_q, seg_d;
    logic [3:0] comm_q, comm_d;

    always_comb begin
        seg_d  = blank[idx_q] ? 8'hFF : seg_dig[idx_q];
        comm_d = ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            seg_q   <= 8'hFF;
            comm_q  <= 4'b1111;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            comm_q  <= comm_d;
        end
    end

    assign seg      = seg_q;
    assign seg_comm = comm_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Randomized bench for fnd_scan_driver against a cycle-count arithmetic model (CLK_HZ=40, SCAN_HZ=4).
module tb_fnd_scan_driver;

    logic        clk;
    logic        reset;
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        bcd_done;
    logic [7:0]  seg;
    logic [3:0]  seg_comm;

    fnd_scan_driver #(.CLK_HZ(40), .SCAN_HZ(4), .MAX_VALUE(9999)) dut (
        .clk(clk), .reset(reset), .bin(bin), .bcd(bcd),
        .bcd_done(bcd_done), .seg(seg), .seg_comm(seg_comm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: t = cycles since the last reset edge. Conversion samples at t%16==0 and
    // publishes at t%16==15; digit index is (t/10)%4; the display lags index/bcd by one cycle.
    int          t = 0;
    int          samp = 0;
    logic [15:0] m_bcd = 16'h0;
    logic        m_done = 1'b0;
    logic [7:0]  m_seg = 8'hFF;
    logic [3:0]  m_comm = 4'hF;
    bit          cmp_en = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
    endfunction

    function automatic logic [7:0] exp_seg(input logic [15:0] b, input int i);
        int v = int'(b);
        int d = (v >> (4 * i)) & 15;
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && (v >> (4 * i)) == 0) return 8'hFF;
`endif
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            t      <= 0;
            m_bcd  <= 16'h0;
            m_done <= 1'b0;
            m_seg  <= 8'hFF;
            m_comm <= 4'hF;
        end else begin
            t <= t + 1;
            if (t % 16 == 0) samp <= (int'(bin) > 9999) ? 9999 : int'(bin);
            if ((t + 1) % 16 == 15) begin
                m_bcd  <= to_bcd(samp);
                m_done <= 1'b1;
            end else begin
                m_done <= 1'b0;
            end
            m_seg  <= exp_seg(m_bcd, (t / 10) % 4);
            m_comm <= 4'hF ^ (4'h1 << ((t / 10) % 4));
        end
        cmp_en <= 1'b1;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %h, expected %h", name, t, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_bcd", bcd, m_bcd);
            check("model_done", 16'(bcd_done), 16'(m_done));
            check("model_seg", 16'(seg), 16'(m_seg));
            check("model_comm", 16'(seg_comm), 16'(m_comm));
        end
    end

    // Advance to the negedge where the model cycle count equals n.
    task automatic wait_t(input int n);
        int g = 0;
        while (t < n && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("wait_t_reached", 16'(t == n), 16'(1));
    endtask

    task automatic wait_phase(input int ph);
        int g = 0;
        @(negedge clk);
        while (t % 16 != ph && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("wait_phase", 16'(t % 16 == ph), 16'(1));
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bin   = 14'd1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_seg", 16'(seg), 16'hFF);
        check("rst_comm", 16'(seg_comm), 16'hF);
        check("rst_bcd", bcd, 16'h0);
        check("rst_done", 16'(bcd_done), 16'h0);
        @(posedge clk);
        #2 reset = 1'b0;

        wait_t(1);
        check("first_seg", 16'(seg), 16'hC0);
        check("first_comm", 16'(seg_comm), 16'hE);
        wait_t(14);
        check("pre_done", 16'(bcd_done), 16'h0);
        wait_t(15);
        check("bcd_1234", bcd, 16'h1234);
        check("done_1234", 16'(bcd_done), 16'h1);
        wait_t(16);
        check("scan_tens_seg", 16'(seg), 16'hB0);
        check("scan_tens_comm", 16'(seg_comm), 16'hD);
        wait_t(21);
        check("scan_hund_seg", 16'(seg), 16'hA4);
        check("scan_hund_comm", 16'(seg_comm), 16'hB);
        wait_t(31);
        check("scan_thou_seg", 16'(seg), 16'hF9);
        check("scan_thou_comm", 16'(seg_comm), 16'h7);
        wait_t(41);
        check("scan_ones_seg", 16'(seg), 16'h99);
        check("scan_ones_comm", 16'(seg_comm), 16'hE);

        // Clamp above MAX_VALUE.
        @(posedge clk); #2 bin = 14'd12000;
        repeat (34) @(negedge clk);
        check("clamp_bcd", bcd, 16'h9999);
        check("clamp_seg", 16'(seg), 16'h90);

        // Input change two cycles into a conversion is ignored until the next IDLE.
        wait_phase(15);
        @(posedge clk); #2 bin = 14'd5;
        repeat (2) @(posedge clk);
        #2 bin = 14'd9999;
        wait_phase(15);
        check("late_change_first", bcd, 16'h0005);
        wait_phase(15);
        check("late_change_second", bcd, 16'h9999);

        // Reset during SHIFT cycle 7 while scan index is 2.
        do_reset(2);
        wait_t(23);
        check("pre_abort_bcd", bcd, 16'h9999);
        reset = 1'b1;
        @(negedge clk);
        check("abort_bcd", bcd, 16'h0);
        check("abort_comm", 16'(seg_comm), 16'hF);
        check("abort_seg", 16'(seg), 16'hFF);
        @(posedge clk); #2 reset = 1'b0;
        wait_t(15);
        check("restart_bcd", bcd, 16'h9999);

`ifdef LEADING_ZERO_BLANK_EN
        bin = 14'd7;
        do_reset(1);
        wait_t(16);
        check("blank_tens", 16'(seg), 16'hFF);
        wait_t(41);
        check("blank_ones_shown", 16'(seg), 16'hF8);
`else
        bin = 14'd0;
        do_reset(1);
        wait_t(16);
        check("zero_tens", 16'(seg), 16'hC0);
        wait_t(41);
        check("zero_ones", 16'(seg), 16'hC0);
`endif

        // Randomized traffic with occasional resets; the compare process checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
            end else begin
                reset = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0: bin = 14'd0;
                    1: bin = 14'd9999;
                    2: bin = 14'd10000;
                    3: bin = 14'd16383;
                    default: bin = 14'($urandom_range(0, 16383));
                endcase
            end
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
